// File: rtl/freq_channel_scheduler_if.sv
// Bundles the scheduler's mux/counter-core and result signals.
// The master modport is the scheduler side; slave is the pad/core/consumer side.
interface freq_channel_scheduler_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_BITS    = 2,
  parameter int unsigned COUNT_BITS = 7
);
  logic [NUM_CH-1:0]     chan_enable;
  logic [CH_BITS-1:0]    chan_sel;
  logic                  gate_start;
  logic                  meas_done;
  logic [COUNT_BITS-1:0] meas_count;
  logic                  result_valid;
  logic [CH_BITS-1:0]    result_chan;
  logic [COUNT_BITS-1:0] result_count;
  logic                  result_timeout;
  logic                  busy;

  modport master (
    input  chan_enable, meas_done, meas_count,
    output chan_sel, gate_start, result_valid, result_chan, result_count,
           result_timeout, busy
  );

  modport slave (
    output chan_enable, meas_done, meas_count,
    input  chan_sel, gate_start, result_valid, result_chan, result_count,
           result_timeout, busy
  );
endinterface

// File: rtl/freq_channel_scheduler.sv
// Round-robin scheduler sharing one frequency-measurement datapath across NUM_CH inputs:
// select channel, let the input synchroniser settle, run one gate window, publish a tagged result.
module freq_channel_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CH_BITS       = 2,
  parameter int unsigned COUNT_BITS    = 7,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1500
) (
  input  logic                          clk,
  input  logic                          reset_n,
  freq_channel_scheduler_if.master      bus
);

  localparam int unsigned SETTLE_BITS = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TIMER_BITS  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    STORE   = 3'd4
  } state_e;

  state_e                 state_q;
  logic [CH_BITS-1:0]     last_chan_q;
  logic [CH_BITS-1:0]     chan_sel_q;
  logic [SETTLE_BITS-1:0] settle_cnt_q;
  logic [TIMER_BITS-1:0]  timer_q;
  logic                   gate_start_q;
  logic                   result_valid_q;
  logic [CH_BITS-1:0]     result_chan_q;
  logic [COUNT_BITS-1:0]  result_count_q;
  logic                   result_timeout_q;
  logic                   busy_q;

  logic                   found_c;
  logic [CH_BITS-1:0]     winner_c;

  // Next enabled channel after last_chan, wrapping; first hit wins.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      logic [CH_BITS-1:0] idx;
      idx = CH_BITS'((32'(last_chan_q) + i) % NUM_CH);
      if (!found_c && bus.chan_enable[idx]) begin
        found_c  = 1'b1;
        winner_c = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      last_chan_q      <= CH_BITS'(NUM_CH - 1);
      chan_sel_q       <= '0;
      settle_cnt_q     <= '0;
      timer_q          <= '0;
      gate_start_q     <= 1'b0;
      result_valid_q   <= 1'b0;
      result_chan_q    <= '0;
      result_count_q   <= '0;
      result_timeout_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      gate_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.chan_enable) begin
            state_q <= SELECT;
            busy_q  <= 1'b1;
          end
        end
        SELECT: begin
          if (found_c) begin
            chan_sel_q   <= winner_c;
            last_chan_q  <= winner_c;
            settle_cnt_q <= '0;
            state_q      <= SETTLE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt_q <= settle_cnt_q + SETTLE_BITS'(1);
          if (settle_cnt_q == SETTLE_BITS'(SETTLE_CYCLES - 1)) begin
            state_q      <= MEASURE;
            gate_start_q <= 1'b1;
            timer_q      <= '0;
          end
        end
        MEASURE: begin
          // meas_done in the gate_start cycle belongs to a stale window.
          if (bus.meas_done && !gate_start_q) begin
            result_count_q   <= bus.meas_count;
            result_timeout_q <= 1'b0;
            result_chan_q    <= chan_sel_q;
            result_valid_q   <= 1'b1;
            state_q          <= STORE;
          end else if (timer_q == TIMER_BITS'(TIMEOUT - 1)) begin
            result_count_q   <= '0;
            result_timeout_q <= 1'b1;
            result_chan_q    <= chan_sel_q;
            result_valid_q   <= 1'b1;
            state_q          <= STORE;
          end else begin
            timer_q <= timer_q + TIMER_BITS'(1);
          end
        end
        STORE: begin
          state_q <= SELECT;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.chan_sel       = chan_sel_q;
  assign bus.gate_start     = gate_start_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_chan    = result_chan_q;
  assign bus.result_count   = result_count_q;
  assign bus.result_timeout = result_timeout_q;
  assign bus.busy           = busy_q;

endmodule
